// File: rtl/add_rr_sched.sv
// add_rr_sched
//   Round-robin front end for a shared combinational adder. Two requesters
//   present operand pairs. One transaction is in flight at a time:
//   accept (IDLE) -> adder settles (ISSUE) -> hold result until taken (RESP).
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   reqN_valid/ready/a/b      requester N operand pair handshake (N = 0, 1)
//   add_a, add_b              registered operands driven to the external adder
//   add_sum, add_cout         adder result returned combinationally
//   rsp_valid/ready           result handshake toward the consumer
//   rsp_id                    requester that owns the result
//   rsp_sum                   {add_cout, add_sum}, ADD_WIDTH+1 bits
//   op_cnt                    completed responses, wraps at 256
module add_rr_sched #(
  parameter int ADD_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [ADD_WIDTH-1:0] req0_a,
  input  logic [ADD_WIDTH-1:0] req0_b,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [ADD_WIDTH-1:0] req1_a,
  input  logic [ADD_WIDTH-1:0] req1_b,
  output logic [ADD_WIDTH-1:0] add_a,
  output logic [ADD_WIDTH-1:0] add_b,
  input  logic [ADD_WIDTH-1:0] add_sum,
  input  logic                 add_cout,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [ADD_WIDTH:0]   rsp_sum,
  output logic [7:0]           op_cnt
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  typedef struct packed {
    logic [ADD_WIDTH-1:0] a;
    logic [ADD_WIDTH-1:0] b;
  } opnd_t;

  state_t state;
  logic   rr_ptr;
  logic   grant;
  logic   accept;
  opnd_t  sel;

  // A lone requester always wins; rr_ptr only breaks ties. Recomputed every
  // cycle, so a requester that drops valid loses nothing it had claimed.
  always_comb begin
    grant = rr_ptr;
    if (req0_valid && !req1_valid)      grant = 1'b0;
    else if (req1_valid && !req0_valid) grant = 1'b1;
  end

  assign req0_ready = !rst && (state == IDLE) && req0_valid && !grant;
  assign req1_ready = !rst && (state == IDLE) && req1_valid &&  grant;
  assign accept     = req0_ready || req1_ready;
  assign sel        = grant ? opnd_t'{req1_a, req1_b} : opnd_t'{req0_a, req0_b};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_sum   <= '0;
      add_a     <= '0;
      add_b     <= '0;
      op_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            add_a  <= sel.a;
            add_b  <= sel.b;
            rsp_id <= grant;
            rr_ptr <= ~grant;
            state  <= ISSUE;
          end
        end
        // add_a/add_b have been stable for a full cycle; adder output is valid.
        ISSUE: begin
          rsp_sum   <= {add_cout, add_sum};
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            op_cnt    <= op_cnt + 8'd1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_add_rr_sched.sv
module tb_add_rr_sched;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [W-1:0] add_a, add_b, add_sum;
  logic         add_cout;
  logic         rsp_valid, rsp_ready, rsp_id;
  logic [W:0]   rsp_sum;
  logic [7:0]   op_cnt;

  add_rr_sched #(.ADD_WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum), .add_cout(add_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sum(rsp_sum), .op_cnt(op_cnt)
  );

  // shared adder
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b};

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int ref_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_edge();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    drive_edge();
    rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    check("ready0_in_rst", req0_ready, 0);
    check("ready1_in_rst", req1_ready, 0);
    drive_edge();
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    ref_cnt = 0;
  endtask

  typedef struct {
    logic       v0, v1;
    logic [W-1:0] a0, b0, a1, b1;
    logic       exp_id;
    logic [W:0] exp_sum;
  } vec_t;

  // One full transaction with rsp_ready=1; valids stay up through ISSUE/RESP
  // so the readies-low check is meaningful.
  task automatic run_txn(input string nm, input vec_t v);
    drive_edge();
    req0_valid = v.v0; req1_valid = v.v1;
    req0_a = v.a0; req0_b = v.b0; req1_a = v.a1; req1_b = v.b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check({nm, "_ready0"}, req0_ready, v.exp_id == 1'b0);
    check({nm, "_ready1"}, req1_ready, v.exp_id == 1'b1);
    drive_edge();
    @(negedge clk);
    check({nm, "_issue_valid"}, rsp_valid, 0);
    check({nm, "_issue_rdy"}, {req0_ready, req1_ready}, 0);
    check({nm, "_add_a"}, add_a, v.exp_id ? v.a1 : v.a0);
    check({nm, "_add_b"}, add_b, v.exp_id ? v.b1 : v.b0);
    drive_edge();
    @(negedge clk);
    check({nm, "_rsp_valid"}, rsp_valid, 1);
    check({nm, "_rsp_id"}, rsp_id, v.exp_id);
    check({nm, "_rsp_sum"}, rsp_sum, v.exp_sum);
    check({nm, "_resp_rdy"}, {req0_ready, req1_ready}, 0);
    ref_cnt++;
    drive_edge();
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    check({nm, "_done_valid"}, rsp_valid, 0);
    check({nm, "_op_cnt"}, op_cnt, ref_cnt[7:0]);
  endtask

  vec_t vecs[6];

  initial begin
    int n;
    bit c255;
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;

    do_reset();
    @(negedge clk);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_sum", rsp_sum, 0);
    check("rst_add_a", add_a, 0);
    check("rst_add_b", add_b, 0);
    check("rst_op_cnt", op_cnt, 0);

    // Expected ids follow the round-robin history from reset (rr starts at 0).
    vecs[0] = '{1, 0, 4'h7, 4'h5, 4'h0, 4'h0, 0, 5'h0C}; // rr -> 1
    vecs[1] = '{1, 1, 4'h3, 4'h4, 4'hF, 4'h1, 1, 5'h10}; // tie, rr=1; rr -> 0
    vecs[2] = '{0, 1, 4'h0, 4'h0, 4'h8, 4'h8, 1, 5'h10}; // lone req1; rr -> 0
    vecs[3] = '{1, 1, 4'hF, 4'hF, 4'h2, 4'h2, 0, 5'h1E}; // tie, rr=0; rr -> 1
    vecs[4] = '{1, 0, 4'h0, 4'h0, 4'h1, 4'h1, 0, 5'h00}; // lone req0; rr -> 1
    vecs[5] = '{1, 1, 4'h1, 4'h1, 4'h9, 4'h6, 1, 5'h0F}; // tie, rr=1; rr -> 0
    foreach (vecs[i]) run_txn($sformatf("vec%0d", i), vecs[i]);

    // Simultaneous requests right after reset: req0 first, then req1.
    do_reset();
    run_txn("dual_first",  '{1, 1, 4'h2, 4'h3, 4'hF, 4'h1, 0, 5'h05});
    run_txn("dual_second", '{1, 1, 4'h2, 4'h3, 4'hF, 4'h1, 1, 5'h10});

    // Backpressure: result held, readies low, IDLE right after handshake.
    drive_edge();
    req0_valid = 1'b1; req1_valid = 1'b0; req0_a = 4'h9; req0_b = 4'h9; rsp_ready = 1'b0;
    @(negedge clk);
    check("bp_accept", req0_ready, 1);
    drive_edge(); req1_valid = 1'b1;
    drive_edge();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("bp_valid", rsp_valid, 1);
      check("bp_sum", rsp_sum, 5'h12);
      check("bp_id", rsp_id, 0);
      check("bp_rdy", {req0_ready, req1_ready}, 0);
      drive_edge();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_hs_valid", rsp_valid, 1);
    check("bp_hs_rdy", {req0_ready, req1_ready}, 0);
    ref_cnt++;
    drive_edge();
    @(negedge clk);
    check("bp_idle_valid", rsp_valid, 0);
    check("bp_idle_ready1", req1_ready, 1);   // rr moved to 1 after req0
    check("bp_op_cnt", op_cnt, ref_cnt[7:0]);
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Reset while in RESP: transaction dropped, rr back to 0.
    drive_edge();
    req0_valid = 1'b1; req0_a = 4'h1; req0_b = 4'h2; rsp_ready = 1'b0;
    @(negedge clk);
    check("mid_accept", req0_ready, 1);
    drive_edge(); req0_valid = 1'b0;
    drive_edge();
    @(negedge clk);
    check("mid_in_resp", rsp_valid, 1);
    drive_edge(); rst = 1'b1;
    @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("mid_rst_rdy", {req0_ready, req1_ready}, 0);
    drive_edge(); rst = 1'b0; ref_cnt = 0;
    @(negedge clk);
    check("mid_valid", rsp_valid, 0);
    check("mid_op_cnt", op_cnt, 0);
    check("mid_grant0", {req0_ready, req1_ready}, 2'b10);
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Fairness: both valid continuously for 8 transactions.
    do_reset();
    drive_edge();
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    n = 0;
    for (int k = 0; k < 100 && n < 8; k++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        check($sformatf("fair_id%0d", n), rsp_id, n % 2);
        n++;
      end
    end
    check("fair_count", n, 8);
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Counter wrap after 256 completed responses.
    do_reset();
    drive_edge();
    req0_valid = 1'b1; req0_a = 4'h3; req0_b = 4'h3; rsp_ready = 1'b1;
    n = 0; c255 = 0;
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      if (n == 255 && !c255) begin check("wrap_255", op_cnt, 255); c255 = 1; end
      if (n == 256) begin check("wrap_0", op_cnt, 0); break; end
      if (rsp_valid && rsp_ready) n++;
    end
    check("wrap_count", n, 256);
    req0_valid = 1'b0;

    // Random traffic against a transaction-level model.
    do_reset();
    begin
      bit busy = 0;
      int age = 0;
      int pref = 0;
      int cnt = 0;
      int g;
      bit er0, er1, eid;
      logic [W:0] es = '0;
      eid = 0;
      for (int k = 0; k < 2000; k++) begin
        drive_edge();
        req0_valid = 1'($urandom_range(0, 1));
        req1_valid = 1'($urandom_range(0, 1));
        req0_a = W'($urandom); req0_b = W'($urandom);
        req1_a = W'($urandom); req1_b = W'($urandom);
        rsp_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        g = (req0_valid && req1_valid) ? pref : (req1_valid ? 1 : 0);
        er0 = !busy && req0_valid && g == 0;
        er1 = !busy && req1_valid && g == 1;
        check("rnd_ready0", req0_ready, er0);
        check("rnd_ready1", req1_ready, er1);
        check("rnd_rsp_valid", rsp_valid, busy && age >= 2);
        if (busy && age >= 2) begin
          check("rnd_rsp_id", rsp_id, eid);
          check("rnd_rsp_sum", rsp_sum, es);
        end
        check("rnd_op_cnt", op_cnt, cnt % 256);
        if (er0 || er1) begin
          busy = 1; age = 1; pref = 1 - g; eid = 1'(g);
          es = g ? ({1'b0, req1_a} + {1'b0, req1_b}) : ({1'b0, req0_a} + {1'b0, req0_b});
        end else if (busy) begin
          if (age >= 2 && rsp_ready) begin busy = 0; cnt++; end
          else age++;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
